branch_predictor_2way: RTL and testbench
========================================

# branch_predictor_2way

Dual-slot bimodal branch predictor for the dual-issue pipeline. It produces one taken/not-taken prediction per fetch slot from a table of 2-bit saturating counters and trains that table with the resolved outcomes of both Execute-stage slots. Its predictions travel down the pipeline and arrive in Execute as `PredictionE1`/`PredictionE2`, where the PC-correction stage compares them with the actual outcomes. It also keeps branch and mispredict counters for performance measurement.

## Interface
Parameters:
- `PC_WIDTH`, 11: PC width in bits (word addresses).
- `INDEX_BITS`, 6: table index width; table depth is 2^INDEX_BITS (64 entries).
- `CNT_WIDTH`, 16: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCF1`, `PCF2`  in  PC_WIDTH  Fetch-stage PCs, slot 1 and slot 2.
- `PredictionF1`, `PredictionF2`  out  1  predicted taken, per fetch slot.
- `branchE1`, `branchE2`  in  1  Execute slot holds a valid conditional branch.
- `PCE1`, `PCE2`  in  PC_WIDTH  Execute-stage PCs.
- `branch_taken1`, `branch_taken2`  in  1  resolved branch outcome.
- `PredictionE1`, `PredictionE2`  in  1  prediction that travelled with each Execute instruction.
- `branchCount`  out  CNT_WIDTH  number of resolved branches.
- `mispredictCount`  out  CNT_WIDTH  number of resolved branches with outcome ≠ prediction.

## Operation
- Index is `PC[INDEX_BITS-1:0]`. Each entry is a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Prediction: `PredictionFn = table[idx(PCFn)][1]`. It is combinational from the current table contents.
- Update: when `branchEn`=1, the entry at `idx(PCEn)` increments on taken (saturates at 11) or decrements on not-taken (saturates at 00). When `branchEn`=0, the slot causes no update and no counting.
- Same-index dual update: when both slots are valid and `idx(PCE1)==idx(PCE2)`, apply slot 1 then slot 2 to the same entry.
  - Examples: 01 with T,T → 11. 11 with NT,T → 11. 00 with NT,NT → 00.
- Counters:
  - `branchCount` += `branchE1 + branchE2`.
  - `mispredictCount` += `(branchE1 & (branch_taken1 ^ PredictionE1)) + (branchE2 & (branch_taken2 ^ PredictionE2))`.
  - Both wrap modulo 2^CNT_WIDTH and add 0, 1 or 2 per cycle.
- Reset: every table entry → 01 (weak-NT), `branchCount` → 0, `mispredictCount` → 0. As a result, `PredictionF1`/`PredictionF2` read 0 after reset.
- `rst` asserted in the same cycle as updates: reset wins and all updates in that cycle are discarded.

## Timing
- Prediction latency is 0 cycles: combinational from `PCF*` and the registered table.
- Update latency is 1 cycle: an update presented in cycle N is visible to predictions from cycle N+1.
- Fetch and update to the same index in the same cycle: the prediction returns the pre-update value. No bypass.
- Counter outputs are registered and reflect all events up to the previous edge.
- There is no handshake. Upstream guarantees the `branchE*` signals are qualified (not flushed, not stalled-duplicate). During a stall, Execute deasserts `branchE*`.

## Structure
- A shared package (`bp_pkg`) holds:
  - counter encodings `SNT`/`WNT`/`WT`/`ST`;
  - the reset value `WNT`;
  - the parameter defaults `PC_WIDTH` and `INDEX_BITS`.
- One sub-module, `sat_counter2`: a combinational next-state function taking (state, valid, taken) and returning the next state. It is instantiated chained, slot 1 → slot 2, for the same-index case and independently otherwise.
- The table is a flop array (64×2), not an SRAM, because it needs a synchronous reset and two write ports.

## Test plan
- Reset, then `PCF1`=0x005 and `PCF2`=0x045 (both index 5) → both `PredictionF` = 0; both counters = 0.
- `branchE1`=1, `PCE1`=0x00A, taken, `PredictionE1`=0 for 2 consecutive cycles → entry 10 = 11; `PredictionF1` for `PCF1`=0x00A = 1 from cycle 2; `mispredictCount`=2, `branchCount`=2.
- Same index, both slots valid: entry 01, slot 1 NT, slot 2 T → entry ends at 01. Both slots T from 10 → 11.
- Saturation: 5 not-taken updates to one entry → 00, stays 00. 5 taken updates → 11.
- Read-during-write: `PCF1`=`PCE1`=0x003 with entry 01, taken → `PredictionF1`=0 this cycle, 1 next cycle.
- Counter wrap: preload `branchCount` to 0xFFFF by running events, then a dual branch → 0x0001. Then assert `rst` together with valid updates → table entries = 01, counters = 0.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and defaults for the dual-slot bimodal predictor.
// Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

    // Default geometry of the predictor and its performance counters
    localparam int BP_PC_WIDTH   = 11;
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_CNT_WIDTH  = 16;

    // 2-bit saturating counter encoding; the MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e RESET_STATE = WNT;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/branch_predictor_2way_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_2way_if
// Description : Fetch/Execute signal bundle between the pipeline and predictor.
// Revision    : 1.0  initial release
// ============================================================================
interface branch_predictor_2way_if
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = BP_PC_WIDTH,
    parameter int CNT_WIDTH = BP_CNT_WIDTH
);

    // Fetch side
    logic [PC_WIDTH-1:0]  PCF1;
    logic [PC_WIDTH-1:0]  PCF2;
    logic                 PredictionF1;
    logic                 PredictionF2;

    // Execute side
    logic                 branchE1;
    logic                 branchE2;
    logic [PC_WIDTH-1:0]  PCE1;
    logic [PC_WIDTH-1:0]  PCE2;
    logic                 branch_taken1;
    logic                 branch_taken2;
    logic                 PredictionE1;
    logic                 PredictionE2;

    // Performance counters
    logic [CNT_WIDTH-1:0] branchCount;
    logic [CNT_WIDTH-1:0] mispredictCount;

    // Pipeline side drives PCs and resolved outcomes
    modport master (
        output PCF1,
        output PCF2,
        input  PredictionF1,
        input  PredictionF2,
        output branchE1,
        output branchE2,
        output PCE1,
        output PCE2,
        output branch_taken1,
        output branch_taken2,
        output PredictionE1,
        output PredictionE2,
        input  branchCount,
        input  mispredictCount
    );

    // Predictor side
    modport slave (
        input  PCF1,
        input  PCF2,
        output PredictionF1,
        output PredictionF2,
        input  branchE1,
        input  branchE2,
        input  PCE1,
        input  PCE2,
        input  branch_taken1,
        input  branch_taken2,
        input  PredictionE1,
        input  PredictionE2,
        output branchCount,
        output mispredictCount
    );

endinterface : branch_predictor_2way_if
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Next-state function of a 2-bit saturating branch counter.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e state_i,
    input  logic valid_i,
    input  logic taken_i,
    output ctr_e next_o
);

    always_comb begin
        next_o = state_i;
        if (valid_i) begin
            case (state_i)
                SNT:     next_o = taken_i ? WNT : SNT;
                WNT:     next_o = taken_i ? WT  : SNT;
                WT:      next_o = taken_i ? ST  : WNT;
                ST:      next_o = taken_i ? ST  : WT;
                default: next_o = state_i;
            endcase
        end
    end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/branch_predictor_2way.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_2way
// Description : Dual-slot bimodal predictor with two training ports and
//               branch / mispredict performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module branch_predictor_2way
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = BP_PC_WIDTH,
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int CNT_WIDTH  = BP_CNT_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst,
    branch_predictor_2way_if.slave  bus
);

    localparam int TABLE_DEPTH = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] w_idx_f1;
    logic [INDEX_BITS-1:0] w_idx_f2;
    logic [INDEX_BITS-1:0] w_idx_e1;
    logic [INDEX_BITS-1:0] w_idx_e2;

    // Flop array: needs synchronous reset and two write ports
    ctr_e table_q [TABLE_DEPTH];
    ctr_e table_d [TABLE_DEPTH];

    ctr_e w_cur1;
    ctr_e w_next1;
    ctr_e w_base2;
    ctr_e w_next2;
    logic w_same_idx;

    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_d;
    logic [1:0]           w_branch_inc;
    logic [1:0]           w_mispred_inc;
    logic                 w_mispred1;
    logic                 w_mispred2;

    assign w_idx_f1 = bus.PCF1[INDEX_BITS-1:0];
    assign w_idx_f2 = bus.PCF2[INDEX_BITS-1:0];
    assign w_idx_e1 = bus.PCE1[INDEX_BITS-1:0];
    assign w_idx_e2 = bus.PCE2[INDEX_BITS-1:0];

    // Predictions read the registered table only; no write bypass
    assign bus.PredictionF1 = table_q[w_idx_f1][1];
    assign bus.PredictionF2 = table_q[w_idx_f2][1];

    // Slot 2 builds on slot 1's result when both train the same entry
    assign w_same_idx = bus.branchE1 && (w_idx_e1 == w_idx_e2);
    assign w_cur1     = table_q[w_idx_e1];
    assign w_base2    = w_same_idx ? w_next1 : table_q[w_idx_e2];

    sat_counter2 u_slot1_ctr (
        .state_i (w_cur1),
        .valid_i (bus.branchE1),
        .taken_i (bus.branch_taken1),
        .next_o  (w_next1)
    );

    sat_counter2 u_slot2_ctr (
        .state_i (w_base2),
        .valid_i (bus.branchE2),
        .taken_i (bus.branch_taken2),
        .next_o  (w_next2)
    );

    // Slot 2 writes last so a shared entry keeps the chained result
    always_comb begin
        table_d = table_q;
        if (bus.branchE1) begin
            table_d[w_idx_e1] = w_next1;
        end
        if (bus.branchE2) begin
            table_d[w_idx_e2] = w_next2;
        end
    end

    assign w_mispred1    = bus.branchE1 & (bus.branch_taken1 ^ bus.PredictionE1);
    assign w_mispred2    = bus.branchE2 & (bus.branch_taken2 ^ bus.PredictionE2);
    assign w_branch_inc  = {1'b0, bus.branchE1} + {1'b0, bus.branchE2};
    assign w_mispred_inc = {1'b0, w_mispred1} + {1'b0, w_mispred2};

    assign branch_cnt_d  = branch_cnt_q  + CNT_WIDTH'(w_branch_inc);
    assign mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(w_mispred_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= RESET_STATE;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.branchCount     = branch_cnt_q;
    assign bus.mispredictCount = mispred_cnt_q;

    // Upper PC bits do not take part in indexing
    logic w_unused_pc;
    assign w_unused_pc = ^{bus.PCF1[PC_WIDTH-1:INDEX_BITS], bus.PCF2[PC_WIDTH-1:INDEX_BITS],
                           bus.PCE1[PC_WIDTH-1:INDEX_BITS], bus.PCE2[PC_WIDTH-1:INDEX_BITS]};

endmodule : branch_predictor_2way
`default_nettype wire

// File: tb/tb_branch_predictor_2way.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_2way
// Description : Directed plus randomized bench with a behavioural table model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor_2way;

    logic clk;
    logic rst;

    branch_predictor_2way_if #(.PC_WIDTH(11), .CNT_WIDTH(16)) bp_bus ();

    branch_predictor_2way #(
        .PC_WIDTH   (11),
        .INDEX_BITS (6),
        .CNT_WIDTH  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bp_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: plain integer counters clamped to 0..3
    int m_tbl [64];
    int m_bc;
    int m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_bc = 0;
        m_mp = 0;
    endtask

    task automatic model_slot(input logic b, input logic [10:0] pc, input logic t, input logic p);
        int ix;
        if (b) begin
            ix = int'(pc) % 64;
            if (t) m_tbl[ix] = (m_tbl[ix] == 3) ? 3 : m_tbl[ix] + 1;
            else   m_tbl[ix] = (m_tbl[ix] == 0) ? 0 : m_tbl[ix] - 1;
            m_bc = (m_bc + 1) % 65536;
            if (t != p) m_mp = (m_mp + 1) % 65536;
        end
    endtask

    task automatic model_apply();
        if (rst) begin
            model_reset();
        end else begin
            model_slot(bp_bus.branchE1, bp_bus.PCE1, bp_bus.branch_taken1, bp_bus.PredictionE1);
            model_slot(bp_bus.branchE2, bp_bus.PCE2, bp_bus.branch_taken2, bp_bus.PredictionE2);
        end
    endtask

    task automatic drive_fetch(input logic [10:0] f1, input logic [10:0] f2);
        bp_bus.PCF1 = f1;
        bp_bus.PCF2 = f2;
    endtask

    task automatic drive_exec(input logic b1, input logic [10:0] pc1, input logic t1, input logic p1,
                              input logic b2, input logic [10:0] pc2, input logic t2, input logic p2);
        bp_bus.branchE1      = b1;
        bp_bus.PCE1          = pc1;
        bp_bus.branch_taken1 = t1;
        bp_bus.PredictionE1  = p1;
        bp_bus.branchE2      = b2;
        bp_bus.PCE2          = pc2;
        bp_bus.branch_taken2 = t2;
        bp_bus.PredictionE2  = p2;
    endtask

    // Clock edge: model sees the same inputs the DUT sampled
    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
    endtask

    function automatic logic exp_pred(input logic [10:0] pc);
        return (m_tbl[int'(pc) % 64] >= 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic check_preds(input string tag);
        check({tag, ".PredF1"}, 32'(bp_bus.PredictionF1), 32'(exp_pred(bp_bus.PCF1)));
        check({tag, ".PredF2"}, 32'(bp_bus.PredictionF2), 32'(exp_pred(bp_bus.PCF2)));
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".branchCount"},     32'(bp_bus.branchCount),     32'(m_bc));
        check({tag, ".mispredictCount"}, 32'(bp_bus.mispredictCount), 32'(m_mp));
    endtask

    task automatic check_entry(input string tag, input int ix, input int exp);
        check(tag, 32'(dut.table_q[ix]), 32'(exp));
    endtask

    initial begin
        int rem;
        logic [10:0] pa;
        logic [10:0] pb;

        rst = 1'b1;
        drive_fetch(11'h000, 11'h000);
        drive_exec(0, 11'h000, 0, 0, 0, 11'h000, 0, 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset state: both slots hit index 5, weak-NT
        drive_fetch(11'h005, 11'h045);
        #1;
        check("reset.PredF1", 32'(bp_bus.PredictionF1), 32'd0);
        check("reset.PredF2", 32'(bp_bus.PredictionF2), 32'd0);
        check_counts("reset");
        check_entry("reset.entry5", 5, 1);

        // Two taken updates to index 10, each mispredicted
        drive_fetch(11'h00A, 11'h045);
        drive_exec(1, 11'h00A, 1, 0, 0, 11'h000, 0, 0);
        #1;
        check("train.pre.PredF1", 32'(bp_bus.PredictionF1), 32'd0);
        tick();
        check("train.c1.PredF1", 32'(bp_bus.PredictionF1), 32'd1);
        tick();
        drive_exec(0, 11'h000, 0, 0, 0, 11'h000, 0, 0);
        #1;
        check_entry("train.entry10", 10, 3);
        check("train.branchCount", 32'(bp_bus.branchCount), 32'd2);
        check("train.mispredictCount", 32'(bp_bus.mispredictCount), 32'd2);
        check_preds("train");

        // Same-index dual update: 01 with NT then T stays 01
        drive_exec(1, 11'h011, 0, 0, 1, 11'h051, 1, 0);
        tick();
        check_entry("dual.nt_t", 17, 1);
        // Bring index 18 to 10, then T,T saturates to 11
        drive_exec(1, 11'h012, 1, 0, 0, 11'h000, 0, 0);
        tick();
        check_entry("dual.prep", 18, 2);
        drive_exec(1, 11'h012, 1, 1, 1, 11'h412, 1, 1);
        tick();
        check_entry("dual.t_t", 18, 3);
        // 01 with T,T reaches 11; 11 with NT,T stays 11
        drive_exec(1, 11'h013, 1, 0, 1, 11'h013, 1, 1);
        tick();
        check_entry("dual.wnt_tt", 19, 3);
        drive_exec(1, 11'h013, 0, 1, 1, 11'h053, 1, 0);
        tick();
        check_entry("dual.st_ntt", 19, 3);
        check_counts("dual");

        // Saturation at both ends
        for (int k = 0; k < 5; k++) begin
            drive_exec(1, 11'h020, 0, 1, 0, 11'h000, 0, 0);
            tick();
            check_entry("sat.down", 32, m_tbl[32]);
        end
        check_entry("sat.floor", 32, 0);
        for (int k = 0; k < 5; k++) begin
            drive_exec(1, 11'h020, 1, 0, 0, 11'h000, 0, 0);
            tick();
        end
        check_entry("sat.ceiling", 32, 3);

        // Read during write returns the old value
        drive_fetch(11'h003, 11'h043);
        drive_exec(1, 11'h003, 1, 0, 0, 11'h000, 0, 0);
        #1;
        check("rdw.same_cycle", 32'(bp_bus.PredictionF1), 32'd0);
        tick();
        drive_exec(0, 11'h000, 0, 0, 0, 11'h000, 0, 0);
        #1;
        check("rdw.next_cycle", 32'(bp_bus.PredictionF1), 32'd1);

        // Drive branchCount to 0xFFFF, then one dual branch wraps to 1
        rem = 65535 - m_bc;
        while (rem >= 2) begin
            drive_exec(1, 11'(rem), rem[0], 1'b0, 1, 11'(rem + 7), rem[1], 1'b1);
            tick();
            rem -= 2;
        end
        if (rem == 1) begin
            drive_exec(1, 11'h030, 1, 1, 0, 11'h000, 0, 0);
            tick();
        end
        drive_exec(0, 11'h000, 0, 0, 0, 11'h000, 0, 0);
        #1;
        check("wrap.preload", 32'(bp_bus.branchCount), 32'hFFFF);
        check("wrap.mispredict", 32'(bp_bus.mispredictCount), 32'(m_mp));
        drive_exec(1, 11'h001, 1, 0, 1, 11'h002, 0, 0);
        tick();
        check("wrap.branchCount", 32'(bp_bus.branchCount), 32'h0001);
        check_counts("wrap");

        // Reset wins over simultaneous updates
        rst = 1'b1;
        drive_exec(1, 11'h00A, 1, 0, 1, 11'h00B, 1, 0);
        tick();
        rst = 1'b0;
        drive_exec(0, 11'h000, 0, 0, 0, 11'h000, 0, 0);
        #1;
        for (int i = 0; i < 64; i++) check_entry("rst_upd.entry", i, 1);
        check("rst_upd.branchCount", 32'(bp_bus.branchCount), 32'd0);
        check("rst_upd.mispredictCount", 32'(bp_bus.mispredictCount), 32'd0);

        // Randomized traffic with frequent index collisions
        for (int n = 0; n < 400; n++) begin
            pa = 11'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? {3'($urandom), pa[5:0]} : 11'($urandom);
            drive_fetch(($urandom_range(0, 1) == 0) ? pa : 11'($urandom), 11'($urandom));
            drive_exec(1'($urandom), pa, 1'($urandom), 1'($urandom),
                       1'($urandom), pb, 1'($urandom), 1'($urandom));
            #1;
            check_preds("rand");
            tick();
            check_counts("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_branch_predictor_2way
`default_nettype wire
